band_bank_player: RTL
=====================

BAND_BANK_PLAYER -- requirements
Module: band_bank_player

Interface
REQ-001 SHALL have parameter NUM_BANDS, default 16, meaning number of bands played per sample strobe.
REQ-002 SHALL have parameter MEM_DEPTH, default 4036, meaning samples stored per band.
REQ-003 SHALL have parameter DATA_W, default 16, meaning sample width in bits.
REQ-004 SHALL have derived localparams ADDR_W = $clog2(MEM_DEPTH) and BAND_W = max(1, $clog2(NUM_BANDS)).
REQ-005 clk  input  1  system clock; reset rst, asynchronous, active-high; clock clk.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 enable  input  1  one-cycle sample strobe, 44 kHz.
REQ-008 play  input  1  level; 1 = run, 0 = pause.
REQ-009 loop_mode  input  1  1 = wrap at end of table, 0 = one-shot.
REQ-010 restart  input  1  one-cycle pulse; rewinds pointer to 0 and clears done and overrun.
REQ-011 mem_addr  output  BAND_W+ADDR_W  shared ROM address {band, sample_ptr}.
REQ-012 mem_rd_en  output  1  ROM read enable.
REQ-013 mem_dout  input  DATA_W  ROM data, valid one cycle after mem_rd_en.
REQ-014 data_out  output  DATA_W (signed)  sample, bit-identical to mem_dout.
REQ-015 band_out  output  BAND_W  band index of data_out.
REQ-016 valid_out  output  1  data_out/band_out valid this cycle.
REQ-017 frame_done  output  1  one-cycle pulse with the last band's valid_out.
REQ-018 busy  output  1  frame in progress.
REQ-019 done  output  1  one-shot table end reached.
REQ-020 overrun  output  1  sticky; strobe arrived while busy.

Function
REQ-021 FSM states SHALL be IDLE, READ, DRAIN, DONE; busy = 1 in READ or DRAIN.
REQ-022 IDLE: enable=1 and play=1 -> READ with band_cnt=0; enable with play=0 -> stay in IDLE, sample_ptr held.
REQ-023 READ: mem_rd_en=1 and mem_addr={band_cnt, sample_ptr} each cycle; band_cnt increments each cycle; after band NUM_BANDS-1 -> DRAIN.
REQ-024 Timing: enable sampled at edge E; band b read in cycle E+1+b; valid_out for band b in cycle E+3+b; outputs SHALL be registered.
REQ-025 valid_out SHALL be high for exactly NUM_BANDS consecutive cycles per frame, with band_out 0..NUM_BANDS-1 in ascending order.
REQ-026 DRAIN: on the edge ending the cycle of the last valid_out, frame_done pulses and sample_ptr advances, then -> IDLE.
REQ-027 Advance: sample_ptr+1 when sample_ptr < MEM_DEPTH-1; at MEM_DEPTH-1, loop_mode=1 -> 0, stay IDLE.
REQ-028 Advance at MEM_DEPTH-1 with loop_mode=0 -> sample_ptr held, done=1, state DONE.
REQ-029 DONE: enable SHALL be ignored, with no mem_rd_en and no valid_out; only restart or rst exits to IDLE.
REQ-030 enable while busy SHALL be dropped, set overrun=1, and leave the current frame unaffected.
REQ-031 restart in IDLE/DONE: sample_ptr=0, done=0, overrun=0, -> IDLE.
REQ-032 restart while busy: the current frame completes; at frame end sample_ptr=0 instead of advancing; done and overrun are cleared.
REQ-033 restart and enable in the same cycle: restart applies first, and the frame plays sample 0.
REQ-034 play falling mid-frame: the frame SHALL still complete; play is sampled only at strobe acceptance.
REQ-035 loop_mode SHALL be sampled only at the advance edge.
REQ-036 valid_out, frame_done and mem_rd_en SHALL be 0 in all cycles not listed above.

Reset
REQ-037 rst SHALL immediately force state=IDLE, sample_ptr=0, band_cnt=0, data_out=0, band_out=0, valid_out=0, frame_done=0, mem_rd_en=0, mem_addr=0, busy=0, done=0, overrun=0.
REQ-038 rst asserted mid-frame SHALL abandon the frame, with no further valid_out; the first strobe after release plays sample 0, band 0.

Verification
REQ-039 Bench SHALL use NUM_BANDS=4, MEM_DEPTH=8, DATA_W=16, and a 1-cycle ROM model with word = band*0x100 + addr, except word{3,5} = 0x8000.
REQ-040 Basic: reset, play=1, one strobe -> valid_out cycles E+3..E+6, band_out 0,1,2,3, data 0x0000,0x0100,0x0200,0x0300; frame_done at E+6.
REQ-041 Wrap: loop_mode=1, 9 strobes -> the 6th frame band 3 gives 0x8000 (negative); the 9th frame gives data 0x0000,0x0100,0x0200,0x0300; done stays 0.
REQ-042 One-shot: loop_mode=0, 8 strobes -> done=1 after the 8th frame_done; the 9th strobe gives no mem_rd_en or valid_out; restart then strobe -> frame at addr 0, done=0.
REQ-043 Overrun and pause: a second strobe 2 cycles after the first -> overrun=1, exactly 4 valid_out; play=0 for 3 strobes -> no reads, and the next played frame uses the held address.
REQ-044 Reset mid-frame: rst after the band-1 valid_out -> all outputs 0 at once; the next strobe yields 0x0000 on band 0.

Source files
------------

// File: rtl/band_bank_player.sv
// band_bank_player: plays NUM_BANDS samples (one per band) from a shared,
// band-banked ROM on every accepted sample strobe. A frame is a burst of
// NUM_BANDS reads followed by a drain, while the ROM latency and the output
// register empty. After the frame the sample pointer advances, wraps, or stops.
//
// state | meaning
// IDLE  | waiting for a strobe; the sample pointer is held
// READ  | issuing one ROM read per cycle, bands 0..NUM_BANDS-1
// DRAIN | reads done; waiting for the last band to leave the output register
// DONE  | one-shot table end reached; strobes ignored until restart or rst
module band_bank_player #(
    parameter int NUM_BANDS = 16,
    parameter int MEM_DEPTH = 4036,
    parameter int DATA_W    = 16,
    localparam int ADDR_W   = $clog2(MEM_DEPTH),
    localparam int BAND_W   = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       play,
    input  logic                       loop_mode,
    input  logic                       restart,
    output logic [BAND_W+ADDR_W-1:0]   mem_addr,
    output logic                       mem_rd_en,
    input  logic [DATA_W-1:0]          mem_dout,
    output logic signed [DATA_W-1:0]   data_out,
    output logic [BAND_W-1:0]          band_out,
    output logic                       valid_out,
    output logic                       frame_done,
    output logic                       busy,
    output logic                       done,
    output logic                       overrun
);

    localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [BAND_W-1:0] LAST_BAND = BAND_W'(NUM_BANDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic [ADDR_W-1:0]          ptr_q, ptr_d;
    logic [BAND_W-1:0]          band_cnt_q, band_cnt_d;
    logic                       mem_rd_en_q, mem_rd_en_d;
    logic [BAND_W+ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                       rd_v_q, rd_v_d;
    logic [BAND_W-1:0]          rd_band_q, rd_band_d;
    logic [DATA_W-1:0]          data_out_q, data_out_d;
    logic [BAND_W-1:0]          band_out_q, band_out_d;
    logic                       valid_out_q, valid_out_d;
    logic                       frame_done_q, frame_done_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       overrun_q, overrun_d;
    logic                       restart_pend_q, restart_pend_d;
    logic [ADDR_W-1:0]          ptr_start;

    // Next-state, read-issue and output-pipeline logic.
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        band_cnt_d     = band_cnt_q;
        mem_rd_en_d    = 1'b0;
        mem_addr_d     = mem_addr_q;
        done_d         = done_q;
        overrun_d      = overrun_q;
        restart_pend_d = restart_pend_q;
        ptr_start      = ptr_q;

        // ROM word arrives the cycle after the read; register it straight out.
        rd_v_d       = mem_rd_en_q;
        rd_band_d    = mem_addr_q[BAND_W+ADDR_W-1:ADDR_W];
        valid_out_d  = rd_v_q;
        data_out_d   = rd_v_q ? mem_dout  : data_out_q;
        band_out_d   = rd_v_q ? rd_band_q : band_out_q;
        frame_done_d = rd_v_q && (rd_band_q == LAST_BAND);

        case (state_q)
            IDLE, DONE: begin
                // Restart takes effect before a same-cycle strobe is judged,
                // so a strobe paired with restart plays sample 0 even from DONE.
                if (restart) begin
                    ptr_d     = '0;
                    ptr_start = '0;
                    done_d    = 1'b0;
                    overrun_d = 1'b0;
                    state_d   = IDLE;
                end
                if (enable && play && (restart || state_q == IDLE)) begin
                    state_d     = READ;
                    band_cnt_d  = '0;
                    mem_rd_en_d = 1'b1;
                    mem_addr_d  = {BAND_W'(0), ptr_start};
                end
            end
            READ: begin
                if (enable)  overrun_d      = 1'b1;
                if (restart) restart_pend_d = 1'b1;
                if (band_cnt_q == LAST_BAND) begin
                    state_d = DRAIN;
                end else begin
                    band_cnt_d  = band_cnt_q + BAND_W'(1);
                    mem_rd_en_d = 1'b1;
                    mem_addr_d  = {band_cnt_q + BAND_W'(1), ptr_q};
                end
            end
            DRAIN: begin
                if (enable)  overrun_d      = 1'b1;
                if (restart) restart_pend_d = 1'b1;
                // frame_done_q marks the cycle of the last valid_out.
                if (frame_done_q) begin
                    state_d = IDLE;
                    if (restart_pend_q || restart) begin
                        ptr_d          = '0;
                        done_d         = 1'b0;
                        overrun_d      = 1'b0;
                        restart_pend_d = 1'b0;
                    end else if (ptr_q != LAST_PTR) begin
                        ptr_d = ptr_q + ADDR_W'(1);
                    end else if (loop_mode) begin
                        ptr_d = '0;
                    end else begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == READ) || (state_d == DRAIN);
    end

    // State and registered outputs; rst clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            band_cnt_q     <= '0;
            mem_rd_en_q    <= 1'b0;
            mem_addr_q     <= '0;
            rd_v_q         <= 1'b0;
            rd_band_q      <= '0;
            data_out_q     <= '0;
            band_out_q     <= '0;
            valid_out_q    <= 1'b0;
            frame_done_q   <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            overrun_q      <= 1'b0;
            restart_pend_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            band_cnt_q     <= band_cnt_d;
            mem_rd_en_q    <= mem_rd_en_d;
            mem_addr_q     <= mem_addr_d;
            rd_v_q         <= rd_v_d;
            rd_band_q      <= rd_band_d;
            data_out_q     <= data_out_d;
            band_out_q     <= band_out_d;
            valid_out_q    <= valid_out_d;
            frame_done_q   <= frame_done_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            overrun_q      <= overrun_d;
            restart_pend_q <= restart_pend_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_rd_en  = mem_rd_en_q;
    assign data_out   = data_out_q;
    assign band_out   = band_out_q;
    assign valid_out  = valid_out_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overrun    = overrun_q;

endmodule
